demux1x7_reg: RTL

DEMUX1X7_REG -- requirements
Module: demux1x7_reg

---
 rtl/demux1x7_reg_pkg.sv | 9 +
 rtl/demux1x7_reg_stream_slot.sv | 42 ++++
 rtl/demux1x7_reg.sv | 68 ++++++
 3 files changed

// File: rtl/demux1x7_reg_pkg.sv
// Shared constants for the registered 1-to-7 stream demultiplexer.
package demux1x7_reg_pkg;

  localparam int unsigned NUM_OUT    = 7;
  localparam int unsigned SEL_W      = 3;
  localparam logic [2:0]  SEL_DROP   = 3'd7;
  localparam int unsigned DROP_CNT_W = 8;

endpackage

// File: rtl/demux1x7_reg_stream_slot.sv
// One-entry valid/data register: load wins over drain, reset clears the entry.
module stream_slot #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      // A load in the same cycle as a drain replaces the departing word.
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/demux1x7_reg.sv
// Registered 1-to-7 stream demultiplexer with a drop code and saturating drop counter.
module demux1x7_reg
  import demux1x7_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic [NUM_OUT-1:0]         out_valid,
  input  logic [NUM_OUT-1:0]         out_ready,
  output logic [NUM_OUT*WIDTH-1:0]   out_data,
  output logic [DROP_CNT_W-1:0]      drop_cnt
);

  // Padded to 8 entries so sel can index them without a range hazard.
  logic [NUM_OUT:0] valid_ext, ready_ext;
  logic             accept;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  assign valid_ext = {1'b0, out_valid};
  assign ready_ext = {1'b0, out_ready};

  always_comb begin
    if (sel == SEL_DROP) begin
      in_ready = 1'b1;
    end else begin
      in_ready = !valid_ext[sel] || ready_ext[sel];
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    drop_d = drop_q;
    if (accept && (sel == SEL_DROP) && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
    stream_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (accept && (sel == SEL_W'(i))),
      .load_data(in_data),
      .drain    (out_ready[i]),
      .valid    (out_valid[i]),
      .data     (out_data[i*WIDTH +: WIDTH])
    );
  end

endmodule
